// File: rtl/l2cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2cache_req_arbiter
// Purpose  : Shares the single L2 request slot between icache, dcache and
//            pipeline cache-ops; holds the winner stable until the core accepts.
// Revision : 1.0
// ============================================================================
module l2cache_req_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    icache_l2cache_req,
  input  logic [ADDR_WIDTH-1:0]   icache_l2cache_addr,
  output logic                    l2cache_icache_addrOK,
  input  logic                    dcache_l2cache_req,
  input  logic                    dcache_l2cache_wr,
  input  logic [ADDR_WIDTH-1:0]   dcache_l2cache_addr,
  input  logic [DATA_WIDTH-1:0]   dcache_l2cache_wdata,
  input  logic [DATA_WIDTH/8-1:0] dcache_l2cache_wstrb,
  input  logic                    dcache_l2cache_SUC,
  output logic                    l2cache_dcache_addrOK,
  input  logic                    pipeline_l2cache_opflag,
  input  logic [31:0]             pipeline_l2cache_opcode,
  input  logic [ADDR_WIDTH-1:0]   pipeline_l2cache_opaddr,
  output logic                    l2cache_pipeline_ack_op,
  output logic [1:0]              arb_from,
  output logic                    arb_opflag,
  output logic [ADDR_WIDTH-1:0]   arb_addr,
  output logic [DATA_WIDTH-1:0]   arb_wdata,
  output logic [DATA_WIDTH/8-1:0] arb_wstrb,
  output logic                    arb_SUC,
  output logic [31:0]             arb_opcode,
  input  logic                    core_icache_addrOK,
  input  logic                    core_dcache_addrOK,
  input  logic                    core_ack_op
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD_I  = 2'd1,
    S_HOLD_D  = 2'd2,
    S_HOLD_OP = 2'd3
  } state_t;

  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_starve_cnt;
  logic [3:0]              w_starve_nxt;
  logic                    w_cap_op;
  logic                    w_cap_i;
  logic                    w_cap_d;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_suc;
  logic                    r_wr;
  logic [31:0]             r_opcode;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_cap_op     = 1'b0;
    w_cap_i      = 1'b0;
    w_cap_d      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pipeline_l2cache_opflag) begin
          w_cap_op    = 1'b1;
          w_state_nxt = S_HOLD_OP;
        end else if (icache_l2cache_req &&
                     (!dcache_l2cache_req || r_starve_cnt == c_STARVE_LIMIT)) begin
          w_cap_i      = 1'b1;
          w_state_nxt  = S_HOLD_I;
          w_starve_nxt = 4'd0;
        end else if (dcache_l2cache_req) begin
          w_cap_d     = 1'b1;
          w_state_nxt = S_HOLD_D;
          // Count only dcache wins that actually bypass a waiting icache fetch.
          if (!icache_l2cache_req)
            w_starve_nxt = 4'd0;
          else if (r_starve_cnt != c_STARVE_LIMIT)
            w_starve_nxt = r_starve_cnt + 4'd1;
        end else if (!icache_l2cache_req) begin
          w_starve_nxt = 4'd0;
        end
      end
      S_HOLD_I:  if (core_icache_addrOK) w_state_nxt = S_IDLE;
      S_HOLD_D:  if (core_dcache_addrOK) w_state_nxt = S_IDLE;
      S_HOLD_OP: if (core_ack_op)        w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_suc        <= 1'b0;
      r_wr         <= 1'b0;
      r_opcode     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_cap_op) begin
        r_addr   <= pipeline_l2cache_opaddr;
        r_opcode <= pipeline_l2cache_opcode;
        r_wdata  <= '0;
        r_wstrb  <= '0;
        r_suc    <= 1'b0;
        r_wr     <= 1'b0;
      end else if (w_cap_i) begin
        r_addr   <= icache_l2cache_addr;
        r_opcode <= '0;
        r_wdata  <= '0;
        r_wstrb  <= '0;
        r_suc    <= 1'b0;
        r_wr     <= 1'b0;
      end else if (w_cap_d) begin
        r_addr   <= dcache_l2cache_addr;
        r_opcode <= '0;
        r_wdata  <= dcache_l2cache_wdata;
        r_wstrb  <= dcache_l2cache_wstrb;
        r_suc    <= dcache_l2cache_SUC;
        r_wr     <= dcache_l2cache_wr;
      end
    end
  end

  // Accepts are gated by the held state so a stray core pulse never leaks out.
  assign l2cache_icache_addrOK   = (r_state == S_HOLD_I)  && core_icache_addrOK;
  assign l2cache_dcache_addrOK   = (r_state == S_HOLD_D)  && core_dcache_addrOK;
  assign l2cache_pipeline_ack_op = (r_state == S_HOLD_OP) && core_ack_op;

  assign arb_from   = (r_state == S_HOLD_I) ? 2'b01 :
                      (r_state == S_HOLD_D) ? {1'b1, r_wr} : 2'b00;
  assign arb_opflag = (r_state == S_HOLD_OP);
  assign arb_addr   = r_addr;
  assign arb_wdata  = r_wdata;
  assign arb_wstrb  = r_wstrb;
  assign arb_SUC    = r_suc;
  assign arb_opcode = r_opcode;

endmodule
`default_nettype wire

// File: tb/tb_l2cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2cache_req_arbiter
// Purpose  : Self-checking bench: request table plus scoreboard of grants.
// Revision : 1.0
// ============================================================================
module tb_l2cache_req_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        icache_l2cache_req;
  logic [31:0] icache_l2cache_addr;
  logic        l2cache_icache_addrOK;
  logic        dcache_l2cache_req;
  logic        dcache_l2cache_wr;
  logic [31:0] dcache_l2cache_addr;
  logic [31:0] dcache_l2cache_wdata;
  logic [3:0]  dcache_l2cache_wstrb;
  logic        dcache_l2cache_SUC;
  logic        l2cache_dcache_addrOK;
  logic        pipeline_l2cache_opflag;
  logic [31:0] pipeline_l2cache_opcode;
  logic [31:0] pipeline_l2cache_opaddr;
  logic        l2cache_pipeline_ack_op;
  logic [1:0]  arb_from;
  logic        arb_opflag;
  logic [31:0] arb_addr;
  logic [31:0] arb_wdata;
  logic [3:0]  arb_wstrb;
  logic        arb_SUC;
  logic [31:0] arb_opcode;
  logic        core_icache_addrOK;
  logic        core_dcache_addrOK;
  logic        core_ack_op;

  l2cache_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .icache_l2cache_req(icache_l2cache_req), .icache_l2cache_addr(icache_l2cache_addr),
    .l2cache_icache_addrOK(l2cache_icache_addrOK),
    .dcache_l2cache_req(dcache_l2cache_req), .dcache_l2cache_wr(dcache_l2cache_wr),
    .dcache_l2cache_addr(dcache_l2cache_addr), .dcache_l2cache_wdata(dcache_l2cache_wdata),
    .dcache_l2cache_wstrb(dcache_l2cache_wstrb), .dcache_l2cache_SUC(dcache_l2cache_SUC),
    .l2cache_dcache_addrOK(l2cache_dcache_addrOK),
    .pipeline_l2cache_opflag(pipeline_l2cache_opflag), .pipeline_l2cache_opcode(pipeline_l2cache_opcode),
    .pipeline_l2cache_opaddr(pipeline_l2cache_opaddr), .l2cache_pipeline_ack_op(l2cache_pipeline_ack_op),
    .arb_from(arb_from), .arb_opflag(arb_opflag), .arb_addr(arb_addr), .arb_wdata(arb_wdata),
    .arb_wstrb(arb_wstrb), .arb_SUC(arb_SUC), .arb_opcode(arb_opcode),
    .core_icache_addrOK(core_icache_addrOK), .core_dcache_addrOK(core_dcache_addrOK),
    .core_ack_op(core_ack_op)
  );

  always #5 clk = ~clk;

  // kind: 0 icache, 1 dcache, 2 cache-op
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        suc;
    logic [31:0] opcode;
    int          waitc;
    bit          drop;
    bit          wrong;
    logic [1:0]  exp_from;
    logic        exp_op;
  } vec_t;

  typedef struct {
    int          kind;
    logic [1:0]  from;
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        suc;
    logic [31:0] opcode;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    icache_l2cache_req = 0; icache_l2cache_addr = 0;
    dcache_l2cache_req = 0; dcache_l2cache_wr = 0; dcache_l2cache_addr = 0;
    dcache_l2cache_wdata = 0; dcache_l2cache_wstrb = 0; dcache_l2cache_SUC = 0;
    pipeline_l2cache_opflag = 0; pipeline_l2cache_opcode = 0; pipeline_l2cache_opaddr = 0;
    core_icache_addrOK = 0; core_dcache_addrOK = 0; core_ack_op = 0;
  endtask

  task automatic drop_req(input int kind);
    case (kind)
      0: icache_l2cache_req = 0;
      1: dcache_l2cache_req = 0;
      default: pipeline_l2cache_opflag = 0;
    endcase
  endtask

  task automatic push_exp(input int kind, input logic [1:0] from, input logic op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic suc, input logic [31:0] opcode);
    exp_t e;
    e.kind = kind; e.from = from; e.op = op; e.addr = addr;
    e.wdata = wdata; e.wstrb = wstrb; e.suc = suc; e.opcode = opcode;
    sbq.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    case (v.kind)
      0: begin icache_l2cache_req = 1; icache_l2cache_addr = v.addr; end
      1: begin
        dcache_l2cache_req = 1; dcache_l2cache_wr = v.wr; dcache_l2cache_addr = v.addr;
        dcache_l2cache_wdata = v.wdata; dcache_l2cache_wstrb = v.wstrb; dcache_l2cache_SUC = v.suc;
      end
      default: begin
        pipeline_l2cache_opflag = 1; pipeline_l2cache_opcode = v.opcode;
        pipeline_l2cache_opaddr = v.addr;
      end
    endcase
    push_exp(v.kind, v.exp_from, v.exp_op, v.addr, v.wdata, v.wstrb, v.suc, v.opcode);
  endtask

  task automatic check_bundle(input string tag, input exp_t e);
    chk({tag, "_from"}, 64'(arb_from), 64'(e.from));
    chk({tag, "_opflag"}, 64'(arb_opflag), 64'(e.op));
    chk({tag, "_addr"}, 64'(arb_addr), 64'(e.addr));
    if (e.kind == 1) begin
      chk({tag, "_wdata"}, 64'(arb_wdata), 64'(e.wdata));
      chk({tag, "_wstrb"}, 64'(arb_wstrb), 64'(e.wstrb));
      chk({tag, "_suc"}, 64'(arb_SUC), 64'(e.suc));
    end else if (e.kind == 2) begin
      chk({tag, "_opcode"}, 64'(arb_opcode), 64'(e.opcode));
    end
  endtask

  function automatic logic [2:0] acks();
    return {l2cache_icache_addrOK, l2cache_dcache_addrOK, l2cache_pipeline_ack_op};
  endfunction

  // Waits for the next grant, checks it against the scoreboard head, holds,
  // optionally pokes mismatched accepts, then accepts and checks the IDLE gap.
  task automatic serve(input int waitc, input bit clr, input bit drop, input bit wrong);
    exp_t e;
    bit   ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arb_from != 2'b00 || arb_opflag) begin ok = 1; break; end
    end
    chk("grant_seen", 64'(ok), 64'd1);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    check_bundle("grant", e);
    if (drop) drop_req(e.kind);
    for (int i = 0; i < waitc; i++) begin
      if (wrong) begin
        core_icache_addrOK = (e.kind != 0);
        core_dcache_addrOK = (e.kind != 1);
        core_ack_op        = (e.kind != 2);
      end
      #1;
      chk("no_early_ack", 64'(acks()), 64'd0);
      @(negedge clk);
      core_icache_addrOK = 0; core_dcache_addrOK = 0; core_ack_op = 0;
      check_bundle("hold", e);
    end
    case (e.kind)
      0: core_icache_addrOK = 1;
      1: core_dcache_addrOK = 1;
      default: core_ack_op = 1;
    endcase
    #1;
    chk("ack_pulse", 64'(acks()), (e.kind == 0) ? 64'd4 : (e.kind == 1) ? 64'd2 : 64'd1);
    @(negedge clk);
    core_icache_addrOK = 0; core_dcache_addrOK = 0; core_ack_op = 0;
    if (clr) drop_req(e.kind);
    chk("idle_from", 64'(arb_from), 64'd0);
    chk("idle_opflag", 64'(arb_opflag), 64'd0);
    chk("idle_acks", 64'(acks()), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    //           kind addr          wr wdata         wstrb suc opcode    wait drop wrong from  op
    vecs[0] = '{0, 32'h1C000000, 0, 32'h0,        4'h0, 0, 32'h0,     3,  0,   0,    2'b01, 0};
    vecs[1] = '{1, 32'hA0000000, 1, 32'hDEADBEEF, 4'hF, 1, 32'h0,     10, 0,   0,    2'b11, 0};
    vecs[2] = '{1, 32'h00001234, 0, 32'h0,        4'h0, 0, 32'h0,     2,  0,   1,    2'b10, 0};
    vecs[3] = '{2, 32'h00000080, 0, 32'h0,        4'h0, 0, 32'h10,    2,  1,   1,    2'b00, 1};
    vecs[4] = '{1, 32'h00000040, 1, 32'h12345678, 4'h3, 0, 32'h0,     1,  1,   0,    2'b11, 0};

    clear_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_from", 64'(arb_from), 64'd0);
    chk("rst_opflag", 64'(arb_opflag), 64'd0);
    chk("rst_payload", {arb_addr, arb_wdata}, 64'd0);
    chk("rst_misc", {arb_opcode, 27'd0, arb_wstrb, arb_SUC}, 64'd0);
    chk("rst_acks", 64'(acks()), 64'd0);
    rstn = 1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      drive(vecs[k]);
      serve(vecs[k].waitc, 1, vecs[k].drop, vecs[k].wrong);
    end

    // Simultaneous op, icache and dcache: op first, then dcache, then icache.
    pipeline_l2cache_opflag = 1; pipeline_l2cache_opcode = 32'h10; pipeline_l2cache_opaddr = 32'h200;
    icache_l2cache_req = 1; icache_l2cache_addr = 32'h1000;
    dcache_l2cache_req = 1; dcache_l2cache_wr = 0; dcache_l2cache_addr = 32'h2000;
    dcache_l2cache_wdata = 0; dcache_l2cache_wstrb = 0; dcache_l2cache_SUC = 0;
    push_exp(2, 2'b00, 1, 32'h200, 0, 0, 0, 32'h10);
    push_exp(1, 2'b10, 0, 32'h2000, 0, 0, 0, 0);
    push_exp(0, 2'b01, 0, 32'h1000, 0, 0, 0, 0);
    serve(1, 1, 0, 0);
    chk("starve_after_op", 64'(dut.r_starve_cnt), 64'd0);
    serve(0, 1, 0, 0);
    chk("starve_after_d", 64'(dut.r_starve_cnt), 64'd1);
    serve(0, 1, 0, 0);
    chk("starve_after_i", 64'(dut.r_starve_cnt), 64'd0);

    // Starvation guard: continuous dcache writes against a waiting fetch.
    icache_l2cache_req = 1; icache_l2cache_addr = 32'h1C000040;
    dcache_l2cache_req = 1; dcache_l2cache_wr = 1; dcache_l2cache_addr = 32'h3000;
    dcache_l2cache_wstrb = 4'hF; dcache_l2cache_SUC = 0;
    for (int k = 0; k < 4; k++) begin
      dcache_l2cache_wdata = 32'h100 + 32'(k);
      push_exp(1, 2'b11, 0, 32'h3000, 32'h100 + 32'(k), 4'hF, 0, 0);
      serve(0, 0, 0, 0);
    end
    chk("starve_sat", 64'(dut.r_starve_cnt), 64'd4);
    push_exp(0, 2'b01, 0, 32'h1C000040, 0, 0, 0, 0);
    serve(0, 1, 0, 0);
    chk("starve_clear", 64'(dut.r_starve_cnt), 64'd0);
    push_exp(1, 2'b11, 0, 32'h3000, 32'h103, 4'hF, 0, 0);
    serve(0, 1, 0, 0);

    // Reset mid-HOLD drops the request without any addrOK.
    icache_l2cache_req = 1; icache_l2cache_addr = 32'h1C000080;
    @(negedge clk);
    chk("pre_rst_from", 64'(arb_from), 64'd1);
    rstn = 0;
    core_icache_addrOK = 1;
    @(negedge clk);
    chk("midrst_from", 64'(arb_from), 64'd0);
    chk("midrst_addr", 64'(arb_addr), 64'd0);
    chk("midrst_acks", 64'(acks()), 64'd0);
    icache_l2cache_req = 0;
    core_icache_addrOK = 0;
    rstn = 1;
    @(negedge clk);
    chk("post_rst_from", 64'(arb_from), 64'd0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
